// File: rtl/fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// fifo_stream_reader
//   Read-side controller for the delayed-flag FIFO. Issues reads only when the
//   FIFO can serve them, follows the FIFO's one-cycle registered read latency,
//   optionally spaces reads by a programmable gap, and buffers words in a
//   4-entry in-order buffer so downstream backpressure never loses data.
//
// Ports
//   i_clk           rising-edge clock
//   i_rst_n         synchronous reset, active low
//   i_enable        1 = fetch from the FIFO; 0 = stop issuing new reads
//   i_cfg_gap       idle cycles inserted between accepted reads
//   i_fifo_empty    FIFO empty flag (registered inside the FIFO)
//   i_fifo_data     FIFO read data, valid the cycle after an accepted read
//   o_fifo_read_en  read request to the FIFO
//   o_m_data        output stream data
//   o_m_valid       output stream valid
//   i_m_ready       output stream ready
//   o_busy          FSM active, read in flight, or buffer not empty
//   o_words_out     handshake counter, saturating (only with FIFO_READER_STATS_EN)
//
// Build option
//   FIFO_READER_STATS_EN : adds o_words_out and its counter.
//
// FSM states
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | no new reads; in-flight and buffered words still drain
//   ST_RUN   | read whenever FIFO non-empty and buffer credit available
//   ST_GAP   | pacing: count down cfg_gap idle cycles before next read
// -----------------------------------------------------------------------------
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 4,
  parameter int GAP_W      = 4,
  parameter int BUF_DEPTH  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_enable,
  input  logic [GAP_W-1:0]      i_cfg_gap,
  input  logic                  i_fifo_empty,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  output logic                  o_fifo_read_en,
  output logic [DATA_WIDTH-1:0] o_m_data,
  output logic                  o_m_valid,
  input  logic                  i_m_ready,
  output logic                  o_busy
`ifdef FIFO_READER_STATS_EN
  ,
  output logic [15:0]           o_words_out
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t                r_state;
  logic [GAP_W-1:0]      r_gap_cnt;
  logic                  r_inflight;
  logic [2:0]            r_occ;
  logic [1:0]            r_wr_ptr;
  logic [1:0]            r_rd_ptr;
  logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];

  logic [3:0]            w_credit_used;
  logic                  w_accept;
  logic                  w_push;
  logic                  w_pop;

  // A word in flight already owns a buffer slot, so it counts against credit;
  // this is what makes a push into a full buffer impossible.
  assign w_credit_used  = {1'b0, r_occ} + {3'b000, r_inflight};
  assign o_fifo_read_en = (r_state == ST_RUN) & ~i_fifo_empty &
                          (w_credit_used < 4'(BUF_DEPTH));
  assign w_accept       = o_fifo_read_en;

  assign w_push    = r_inflight;
  assign o_m_valid = (r_occ != 3'd0);
  assign w_pop     = o_m_valid & i_m_ready;
  assign o_m_data  = r_mem[r_rd_ptr];
  assign o_busy    = (r_state != ST_IDLE) | r_inflight | o_m_valid;

  // Read pacing FSM. Loading cfg_gap on the accepted read and leaving GAP when
  // the count reaches 1 yields exactly cfg_gap idle cycles between reads.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_gap_cnt <= '0;
    end else if (!i_enable) begin
      r_state   <= ST_IDLE;
      r_gap_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: r_state <= ST_RUN;
        ST_RUN: begin
          if (w_accept && (i_cfg_gap != '0)) begin
            r_state   <= ST_GAP;
            r_gap_cnt <= i_cfg_gap;
          end
        end
        ST_GAP: begin
          r_gap_cnt <= r_gap_cnt - GAP_W'(1);
          if (r_gap_cnt == GAP_W'(1)) begin
            r_state <= ST_RUN;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Read tracking and output buffer.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_inflight <= 1'b0;
      r_occ      <= 3'd0;
      r_wr_ptr   <= 2'd0;
      r_rd_ptr   <= 2'd0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_inflight <= w_accept;
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_fifo_data;
        r_wr_ptr        <= r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 3'd1;
        2'b01:   r_occ <= r_occ - 3'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

`ifdef FIFO_READER_STATS_EN
  logic [15:0] r_words_out;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_words_out <= 16'd0;
    end else if (w_pop && (r_words_out != 16'hFFFF)) begin
      r_words_out <= r_words_out + 16'd1;
    end
  end

  assign o_words_out = r_words_out;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// Testbench for fifo_stream_reader. Models the delayed-flag FIFO as a queue,
// keeps an in-order scoreboard of every word written into that FIFO, and
// checks stream ordering, credit limit, stall hold and read gating each cycle.
// -----------------------------------------------------------------------------
module tb_fifo_stream_reader;
  localparam int DW = 4;
  localparam int GW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [GW-1:0] cfg_gap = '0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_read_en;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          busy;
`ifdef FIFO_READER_STATS_EN
  logic [15:0]   words_out;
`endif

  always #5 clk = ~clk;

  fifo_stream_reader #(.DATA_WIDTH(DW), .GAP_W(GW), .BUF_DEPTH(4)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_enable       (enable),
    .i_cfg_gap      (cfg_gap),
    .i_fifo_empty   (fifo_empty),
    .i_fifo_data    (fifo_data),
    .o_fifo_read_en (fifo_read_en),
    .o_m_data       (m_data),
    .o_m_valid      (m_valid),
    .i_m_ready      (m_ready),
    .o_busy         (busy)
`ifdef FIFO_READER_STATS_EN
    ,
    .o_words_out    (words_out)
`endif
  );

  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc = 0;
  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];
  int            acc_cyc[$];
  int            hs_cyc[$];
  int            outstanding = 0;
  logic          hold_empty_low = 1'b0;
  logic          last_en = 1'b0;
  logic          last_stall = 1'b0;
  logic [DW-1:0] last_data = '0;

  typedef struct {
    int gap;
    int nwords;
    int spacing;
    int lat;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
  endtask

  // One clock: observe at the falling edge, then update the FIFO model
  // shortly after the rising edge, exactly like a registered FIFO would.
  task automatic tick();
    logic acc;
    logic hs;
    @(negedge clk);
    acc = fifo_read_en & ~fifo_empty;
    hs  = m_valid & m_ready;
    if (rst_n) begin
      if (fifo_read_en) chk("read_en_while_empty", {31'd0, fifo_empty}, 0);
      if (!last_en) chk("read_after_disable", {31'd0, fifo_read_en}, 0);
      if (last_stall) begin
        chk("stall_hold_valid", {31'd0, m_valid}, 1);
        chk("stall_hold_data", {28'd0, m_data}, {28'd0, last_data});
      end
      if (acc) begin
        acc_cyc.push_back(cyc);
        outstanding++;
      end
      if (hs) begin
        hs_cyc.push_back(cyc);
        outstanding--;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_word: got %0d, expected no word", m_data);
        end else begin
          chk("stream_data", {28'd0, m_data}, {28'd0, exp_q.pop_front()});
        end
      end
      if (acc) chk("credit_limit", {31'd0, outstanding <= 4}, 1);
    end
    last_en    = enable & rst_n;
    last_stall = rst_n & m_valid & ~m_ready;
    last_data  = m_data;
    @(posedge clk);
    cyc++;
    #1;
    if (!rst_n) begin
      fq.delete();
      exp_q.delete();
      outstanding = 0;
      fifo_empty  = ~hold_empty_low;
    end else begin
      if (acc) fifo_data = fq.pop_front();
      fifo_empty = (fq.size() == 0);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int a0;
    int h0;
    int t;
    a0 = acc_cyc.size();
    h0 = hs_cyc.size();
    cfg_gap = GW'(v.gap);
    m_ready = 1'b1;
    for (int i = 0; i < v.nwords; i++) push_word(DW'((i * 3 + v.gap + idx + 1) % 16));
    tick();
    enable = 1'b1;
    t = 0;
    while (t < 300 && (hs_cyc.size() - h0) < v.nwords) begin
      tick();
      t++;
    end
    chk("vec_words_out", hs_cyc.size() - h0, v.nwords);
    chk("vec_reads", acc_cyc.size() - a0, v.nwords);
    if ((hs_cyc.size() - h0) == v.nwords && (acc_cyc.size() - a0) == v.nwords) begin
      chk("vec_latency", hs_cyc[h0] - acc_cyc[a0], v.lat);
      for (int k = 1; k < v.nwords; k++) begin
        chk("vec_read_spacing", acc_cyc[a0 + k] - acc_cyc[a0 + k - 1], v.spacing);
        chk("vec_out_spacing", hs_cyc[h0 + k] - hs_cyc[h0 + k - 1], v.spacing);
      end
    end
    enable = 1'b0;
    repeat (3) tick();
    chk("vec_idle_busy", {31'd0, busy}, 0);
  endtask

  task automatic test_backpressure();
    int a0;
    int h0;
    int t;
    do_reset();
    cfg_gap = '0;
    m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push_word(DW'(i));
    tick();
    enable = 1'b1;
    a0 = acc_cyc.size();
    h0 = hs_cyc.size();
    repeat (12) tick();
    chk("bp_reads_accepted", acc_cyc.size() - a0, 4);
    chk("bp_read_en_low", {31'd0, fifo_read_en}, 0);
    chk("bp_busy", {31'd0, busy}, 1);
    chk("bp_valid", {31'd0, m_valid}, 1);
    chk("bp_head", {28'd0, m_data}, 1);
    m_ready = 1'b1;
    t = 0;
    while (t < 100 && (hs_cyc.size() - h0) < 8) begin
      tick();
      t++;
    end
    chk("bp_delivered", hs_cyc.size() - h0, 8);
    chk("bp_scoreboard_left", exp_q.size(), 0);
`ifdef FIFO_READER_STATS_EN
    chk("bp_words_out", {16'd0, words_out}, 8);
`endif
    enable = 1'b0;
    repeat (3) tick();
    chk("bp_idle_busy", {31'd0, busy}, 0);
  endtask

  task automatic test_enable_drop();
    int a0;
    int h0;
    int a1;
    int t;
    cfg_gap = GW'(2);
    m_ready = 1'b1;
    push_word(DW'(9));
    push_word(DW'(10));
    push_word(DW'(11));
    tick();
    a0 = acc_cyc.size();
    h0 = hs_cyc.size();
    enable = 1'b1;
    t = 0;
    while (t < 20 && acc_cyc.size() == a0) begin
      tick();
      t++;
    end
    chk("drop_first_read", acc_cyc.size() - a0, 1);
    enable = 1'b0;
    a1 = acc_cyc.size();
    repeat (10) tick();
    chk("drop_no_more_reads", acc_cyc.size() - a1, 0);
    chk("drop_word_delivered", hs_cyc.size() - h0, 1);
    chk("drop_busy_after_drain", {31'd0, busy}, 0);
    do_reset();
  endtask

  task automatic test_reset_midflight();
    int a0;
    int h0;
    int t;
    cfg_gap = '0;
    m_ready = 1'b0;
    push_word(DW'(5));
    push_word(DW'(6));
    push_word(DW'(7));
    tick();
    a0 = acc_cyc.size();
    enable = 1'b1;
    t = 0;
    while (t < 20 && (acc_cyc.size() - a0) < 3) begin
      tick();
      t++;
    end
    chk("rst6_reads", acc_cyc.size() - a0, 3);
    chk("rst6_pre_valid", {31'd0, m_valid}, 1);
    do_reset();
    chk("rst6_valid", {31'd0, m_valid}, 0);
    chk("rst6_data", {28'd0, m_data}, 0);
    chk("rst6_busy", {31'd0, busy}, 0);
`ifdef FIFO_READER_STATS_EN
    chk("rst6_words_out", {16'd0, words_out}, 0);
`endif
    m_ready = 1'b1;
    h0 = hs_cyc.size();
    repeat (10) tick();
    chk("rst6_nothing_delivered", hs_cyc.size() - h0, 0);
    enable = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_random();
    int t;
    enable = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) < 55 && fq.size() < 16) push_word(DW'($urandom_range(0, 15)));
      m_ready = ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 99) < 3) enable = ~enable;
      if ($urandom_range(0, 99) < 5) cfg_gap = GW'($urandom_range(0, 3));
      tick();
    end
    enable  = 1'b1;
    m_ready = 1'b1;
    t = 0;
    while (t < 500 && exp_q.size() != 0) begin
      tick();
      t++;
    end
    chk("rand_all_delivered", exp_q.size(), 0);
    enable = 1'b0;
    repeat (4) tick();
    chk("rand_idle_busy", {31'd0, busy}, 0);
  endtask

  initial begin
    vecs[0] = '{gap: 0, nwords: 4, spacing: 1, lat: 2};
    vecs[1] = '{gap: 3, nwords: 8, spacing: 4, lat: 2};
    vecs[2] = '{gap: 1, nwords: 5, spacing: 2, lat: 2};
    vecs[3] = '{gap: 7, nwords: 3, spacing: 8, lat: 2};

    // Reset held with enable high and the FIFO reporting data.
    rst_n          = 1'b0;
    enable         = 1'b1;
    hold_empty_low = 1'b1;
    fifo_empty     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_read_en", {31'd0, fifo_read_en}, 0);
      chk("reset_valid", {31'd0, m_valid}, 0);
      chk("reset_data", {28'd0, m_data}, 0);
      chk("reset_busy", {31'd0, busy}, 0);
    end
    hold_empty_low = 1'b0;
    enable         = 1'b0;
    fifo_empty     = 1'b1;
    rst_n          = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) run_vec(vecs[i], i);
    test_backpressure();
    test_enable_drop();
    test_reset_midflight();
    test_random();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
